// File: rtl/dual_input_debouncer.sv
// Dual-channel input conditioner for push-buttons / switches.
// Each channel: 2-FF synchronizer -> 4-state debounce FSM with a stability
// counter -> registered clean level (x_db) and single-cycle rise tick (x_tick).
// Channels A and B are identical and share nothing but clock and reset.
//
// Debounce FSM states (per channel):
//   state | meaning
//   ------+-------------------------------------------------------------
//   ZERO  | debounced level 0, input agrees
//   WAIT1 | debounced level 0, input reads 1, counting toward DB_COUNT-1
//   ONE   | debounced level 1, input agrees
//   WAIT0 | debounced level 1, input reads 0, counting toward DB_COUNT-1
//
// A qualifying change needs the synchronized input to hold the new value on
// DB_COUNT+1 consecutive edges (the entry edge plus DB_COUNT counting edges),
// giving DB_COUNT+3 edges of raw-to-output latency including the two
// synchronizer stages.
module dual_input_debouncer #(
  parameter int DB_COUNT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_tick,
  output logic b_tick
);

  // Width of the stability counter; it only ever needs to reach DB_COUNT-1.
  localparam int CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  // Gray-ish encoding: bit 1 doubles as the debounced level, but the output
  // is still kept in its own flop so downstream never sees decode logic.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b11,
    WAIT0 = 2'b10
  } state_t;

  logic [1:0] raw_vec;
  logic [1:0] db_vec;
  logic [1:0] tick_vec;

  assign raw_vec = {b_raw, a_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic              s1_q;
    logic              s2_q;
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              db_q;
    logic              tick_q;

    // Two-stage synchronizer; the FSM only ever looks at s2_q.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= raw_vec[ch];
        s2_q <= s1_q;
      end
    end

    // Debounce FSM with registered level and rise-tick outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ZERO;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        case (state_q)
          ZERO: begin
            if (s2_q) begin
              state_q <= WAIT1;
              cnt_q   <= '0;
            end
          end
          WAIT1: begin
            if (!s2_q) begin
              // Excursion too short: drop back, no tick.
              state_q <= ZERO;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= ONE;
              db_q    <= 1'b1;
              tick_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ONE: begin
            if (!s2_q) begin
              state_q <= WAIT0;
              cnt_q   <= '0;
            end
          end
          WAIT0: begin
            if (s2_q) begin
              // Glitch low rejected; level never dropped, so no tick either.
              state_q <= ONE;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= ZERO;
              db_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= ZERO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
          end
        endcase
      end
    end

    assign db_vec[ch]   = db_q;
    assign tick_vec[ch] = tick_q;
  end

  assign a_db   = db_vec[0];
  assign b_db   = db_vec[1];
  assign a_tick = tick_vec[0];
  assign b_tick = tick_vec[1];

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Bench for dual_input_debouncer with DB_COUNT=4.
// Reference model: a raw-sample history per channel; the debounced level
// flips when the last DB_COUNT+1 synchronized samples all differ from it.
module tb_dual_input_debouncer;

  localparam int DB = 4;
  localparam int HW = DB + 2;

  logic clk;
  logic rst;
  logic a_raw;
  logic b_raw;
  logic a_db;
  logic b_db;
  logic a_tick;
  logic b_tick;

  int checks;
  int errors;

  dual_input_debouncer #(.DB_COUNT(DB)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a_db   (a_db),
    .b_db   (b_db),
    .a_tick (a_tick),
    .b_tick (b_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. ah[0] holds the raw value sampled one edge ago, so
  // ah[1] is what the debouncer sees this edge and ah[HW-1:1] is the window.
  logic [HW-1:0] ah;
  logic [HW-1:0] bh;
  logic m_adb;
  logic m_bdb;
  logic m_atk;
  logic m_btk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ah    <= '0;
      bh    <= '0;
      m_adb <= 1'b0;
      m_bdb <= 1'b0;
      m_atk <= 1'b0;
      m_btk <= 1'b0;
    end else begin
      m_atk <= (ah[HW-1:1] == {(DB+1){1'b1}}) && !m_adb;
      m_btk <= (bh[HW-1:1] == {(DB+1){1'b1}}) && !m_bdb;
      if (ah[HW-1:1] == {(DB+1){~m_adb}}) m_adb <= ~m_adb;
      if (bh[HW-1:1] == {(DB+1){~m_bdb}}) m_bdb <= ~m_bdb;
      ah <= {ah[HW-2:0], a_raw};
      bh <= {bh[HW-2:0], b_raw};
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    a_raw = 1'b0;
    b_raw = 1'b0;
    rst   = 1'b1;
    step();
    step();
    checks++;
    if ({a_db, b_db, a_tick, b_tick} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0000", {a_db, b_db, a_tick, b_tick});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({a_db, b_db, a_tick, b_tick} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release got=%b exp=0000", {a_db, b_db, a_tick, b_tick});
    end
  endtask

  task automatic test_rise_latency();
    do_reset();
    a_raw = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (a_db !== (k >= 6)) begin
        errors++;
        $display("FAIL rise_a_db k=%0d got=%b exp=%b", k, a_db, (k >= 6));
      end
      checks++;
      if (a_tick !== (k == 6)) begin
        errors++;
        $display("FAIL rise_a_tick k=%0d got=%b exp=%b", k, a_tick, (k == 6));
      end
      checks++;
      if ({b_db, b_tick} !== 2'b00) begin
        errors++;
        $display("FAIL rise_b_quiet k=%0d got=%b exp=00", k, {b_db, b_tick});
      end
      checks++;
      if ({a_db, b_db, a_tick, b_tick} !== {m_adb, m_bdb, m_atk, m_btk}) begin
        errors++;
        $display("FAIL rise_model k=%0d got=%b exp=%b", k, {a_db, b_db, a_tick, b_tick},
                 {m_adb, m_bdb, m_atk, m_btk});
      end
    end
  endtask

  task automatic test_glitch_rise();
    do_reset();
    a_raw = 1'b1;
    repeat (3) step();
    a_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({a_db, a_tick} !== 2'b00) begin
        errors++;
        $display("FAIL glitch_rise k=%0d got=%b exp=00", k, {a_db, a_tick});
      end
    end
    // A fresh excursion must see the full latency again.
    a_raw = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if ({a_db, a_tick} !== {(k >= 6), (k == 6)}) begin
        errors++;
        $display("FAIL glitch_recover k=%0d got=%b exp=%b", k, {a_db, a_tick},
                 {(k >= 6), (k == 6)});
      end
    end
  endtask

  task automatic test_glitch_fall();
    a_raw = 1'b0;
    repeat (2) step();
    a_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({a_db, a_tick} !== 2'b10) begin
        errors++;
        $display("FAIL glitch_fall k=%0d got=%b exp=10", k, {a_db, a_tick});
      end
    end
    a_raw = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if ({a_db, a_tick} !== {(k < 6), 1'b0}) begin
        errors++;
        $display("FAIL fall_latency k=%0d got=%b exp=%b", k, {a_db, a_tick}, {(k < 6), 1'b0});
      end
      checks++;
      if ({a_db, b_db, a_tick, b_tick} !== {m_adb, m_bdb, m_atk, m_btk}) begin
        errors++;
        $display("FAIL fall_model k=%0d got=%b exp=%b", k, {a_db, b_db, a_tick, b_tick},
                 {m_adb, m_bdb, m_atk, m_btk});
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] e;
    do_reset();
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      e = {(k >= 6), (k >= 6), (k == 6), (k == 6)};
      checks++;
      if ({a_db, b_db, a_tick, b_tick} !== e) begin
        errors++;
        $display("FAIL simultaneous k=%0d got=%b exp=%b", k, {a_db, b_db, a_tick, b_tick}, e);
      end
    end
    b_raw = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_raw = 1'b1;
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_db, a_tick} !== 2'b00) begin
      errors++;
      $display("FAIL reset_wait1 got=%b exp=00", {a_db, a_tick});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      checks++;
      if ({a_db, a_tick} !== {(k >= 6), (k == 6)}) begin
        errors++;
        $display("FAIL reset_restart k=%0d got=%b exp=%b", k, {a_db, a_tick},
                 {(k >= 6), (k == 6)});
      end
    end
    // Reset landing on the tick cycle must clear both outputs at once.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_db, a_tick} !== 2'b00) begin
      errors++;
      $display("FAIL reset_on_tick got=%b exp=00", {a_db, a_tick});
    end
    @(negedge clk);
    a_raw = 1'b0;
    rst   = 1'b0;
    step();
  endtask

  task automatic test_bounce();
    int total;
    int len;
    int ticks;
    int rise_k;
    do_reset();
    a_raw = 1'b0;
    total = 0;
    while (total < 40) begin
      len   = $urandom_range(1, 3);
      a_raw = ~a_raw;
      for (int i = 0; i < len; i++) begin
        step();
        checks++;
        if ({a_db, a_tick} !== 2'b00) begin
          errors++;
          $display("FAIL bounce_quiet t=%0t got=%b exp=00", $time, {a_db, a_tick});
        end
      end
      total += len;
    end
    a_raw = 1'b0;
    step();
    a_raw  = 1'b1;
    ticks  = 0;
    rise_k = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (a_tick === 1'b1) ticks++;
      if (a_db === 1'b1 && rise_k < 0) rise_k = k;
      checks++;
      if ({a_db, b_db, a_tick, b_tick} !== {m_adb, m_bdb, m_atk, m_btk}) begin
        errors++;
        $display("FAIL bounce_model k=%0d got=%b exp=%b", k, {a_db, b_db, a_tick, b_tick},
                 {m_adb, m_bdb, m_atk, m_btk});
      end
    end
    checks++;
    if (ticks != 1) begin
      errors++;
      $display("FAIL bounce_tick_count got=%0d exp=1", ticks);
    end
    checks++;
    if (rise_k != 6) begin
      errors++;
      $display("FAIL bounce_rise_edge got=%0d exp=6", rise_k);
    end
  endtask

  task automatic test_random();
    int a_left;
    int b_left;
    do_reset();
    a_left = 0;
    b_left = 0;
    for (int n = 0; n < 600; n++) begin
      if (a_left == 0) begin
        a_raw  = 1'($urandom_range(0, 1));
        a_left = $urandom_range(1, 9);
      end
      if (b_left == 0) begin
        b_raw  = 1'($urandom_range(0, 1));
        b_left = $urandom_range(1, 9);
      end
      a_left--;
      b_left--;
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_db, b_db, a_tick, b_tick} !== 4'b0000) begin
          errors++;
          $display("FAIL random_reset n=%0d got=%b exp=0000", n, {a_db, b_db, a_tick, b_tick});
        end
        @(negedge clk);
        rst = 1'b0;
      end
      step();
      checks++;
      if ({a_db, b_db, a_tick, b_tick} !== {m_adb, m_bdb, m_atk, m_btk}) begin
        errors++;
        $display("FAIL random_model n=%0d got=%b exp=%b", n, {a_db, b_db, a_tick, b_tick},
                 {m_adb, m_bdb, m_atk, m_btk});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    a_raw  = 1'b0;
    b_raw  = 1'b0;
    @(negedge clk);
    test_reset();
    test_rise_latency();
    test_glitch_rise();
    test_glitch_fall();
    test_simultaneous();
    test_reset_mid();
    test_bounce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout t=%0t got=running exp=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
